powlib_iprdreq: RTL and testbench
=================================

Name: powlib_iprdreq

Overview:
- Read-request master that sits directly upstream of the IP RAM slave on the packed bus.
- Accepts one command giving a start address and a word count. Issues that many READ requests with incrementing addresses, each carrying a return address in its data field.
- Bounds the number of outstanding reads, consumes the write-op responses the slave returns, and presents them as indexed read data.
- Pulses done once every response of the command has been received.

Parameters:
- B_BPD, 4, bytes per data word; B_DW = POWLIB_BW*B_BPD, B_BEW = B_BPD, B_WW = B_OPW+B_BEW+B_DW.
- B_AW, POWLIB_BW*B_BPD, address width; must be <= B_DW.
- RET_BASE, 0, base return address placed in the request data field.
- MAX_OUT, 8, maximum outstanding reads (1..255).
- CNT_W, 16, width of the command word count.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- cmdaddr, in, B_AW, start byte address (word-aligned).
- cmdcnt, in, CNT_W, number of words to read.
- cmdvld, in, 1, command valid.
- cmdrdy, out, 1, command ready.
- wraddr, out, B_AW, request address.
- wrdata, out, B_WW, packed request: data = return address zero-extended, be = all ones, op = POWLIB_OP_READ.
- wrvld, out, 1, request valid.
- wrrdy, in, 1, request ready.
- rsaddr, in, B_AW, response address (the return address).
- rsdata, in, B_WW, packed response.
- rsvld, in, 1, response valid.
- rsrdy, out, 1, response ready.
- respdata, out, B_DW, read data.
- respidx, out, CNT_W, word index within the command.
- respvld, out, 1, response valid.
- resprdy, in, 1, response ready.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, sticky error (only with the optional feature).

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: all registers clear. cmdrdy=0 while rst is high, 1 in IDLE after reset. wrvld=0, respvld=0, done=0, err=0, outstanding=0, FSM=IDLE.
- Handshake: a transfer occurs on a cycle where vld&&rdy. vld, once raised, is held with stable payload until accepted.
- FSM, IDLE:
  - cmdrdy=1.
  - On cmdvld: capture addr, cnt; set issue offset off=0, expected index exp=0.
  - cnt==0: done pulses the next cycle; FSM stays IDLE.
  - Otherwise go to ISSUE.
- FSM, ISSUE:
  - cmdrdy=0; wrvld = (outstanding<MAX_OUT), combinational from registered state.
  - wraddr = addr + off*B_BPD (mod 2^B_AW).
  - Request data field = RET_BASE + off*B_BPD (mod 2^B_AW).
  - On accept: off++, outstanding++. When off reaches cnt, go to DRAIN; wrvld is 0 from the next cycle.
- FSM, DRAIN:
  - Wait for outstanding==0, then pulse done for 1 cycle and return to IDLE.
  - cmdrdy rises the cycle after done.
- Outstanding counter:
  - Width clog2(MAX_OUT+1).
  - A request accept and a response accept in the same cycle leave it unchanged.
  - A response accepted with outstanding==0 does not decrement it (saturates at 0).
- Response path:
  - One output register; rsrdy = !respvld || resprdy.
  - On rs accept: respdata = rsdata data field; respidx = (rsaddr-RET_BASE)>>clog2(B_BPD), truncated to CNT_W; respvld=1.
  - respvld clears on resprdy when no new rs accept occurs that cycle.
  - Latency rsvld to respvld is 1 cycle; full throughput of 1 response/cycle is sustained while resprdy=1.
  - Responses are assumed in order: exp++ on each accept.
  - rsdata be and op fields are ignored.
- Throughput: 1 request/cycle while wrrdy=1 and credit is available.
- Wrap-around: address and return address wrap modulo 2^B_AW with no error.
- Command during ISSUE/DRAIN: not accepted (cmdrdy=0).
- Reset mid-operation: all state is dropped immediately. Late responses after reset are passed through; the counter saturates.

Optional Feature:
- Macro: POWLIB_IPRDREQ_CHECK_EN.
- When defined, err is set sticky on either condition; only rst clears it.
  - A response is accepted with outstanding==0.
  - An accepted rsaddr != RET_BASE + exp*B_BPD.
- When not defined, err is tied to 0 and no comparison logic is built.

Test Plan:
- Reset then command addr=0x10, cnt=4, wrrdy=1, RET_BASE=0x100 -> wraddr 0x10,0x14,0x18,0x1C on 4 consecutive cycles; data fields 0x100..0x10C; op=READ, be=0xF.
- MAX_OUT=2, cnt=5, responses withheld -> exactly 2 requests issued, wrvld=0. Return one response -> exactly one more request issues.
- Responses 0xA..0xD at rsaddr 0x100..0x10C with resprdy toggling 1/0 -> respidx 0..3 with matching data, none lost. done pulses 1 cycle after the last response is accepted.
- cnt=0 -> done pulses next cycle, no wrvld, cmdrdy stays 1.
- rst asserted mid-ISSUE (off=2 of 6) -> wrvld=0 and FSM=IDLE immediately. A new command restarts at off=0.
- CHECK_EN: response with rsaddr 0x108 when 0x104 is expected -> err=1 and stays 1 until rst. A stray response with outstanding=0 also sets err.

Source files
------------

// File: rtl/powlib_iprdreq_if.sv
// Shared powlib bus constants plus the bundled command / request / response
// signals of the IP RAM read-request master.
package powlib_pkg;
    localparam int POWLIB_BW = 8;
    localparam int B_OPW = 1;
    localparam logic [B_OPW-1:0] POWLIB_OP_WRITE = 1'b0;
    localparam logic [B_OPW-1:0] POWLIB_OP_READ  = 1'b1;
endpackage

interface powlib_iprdreq_if #(
    parameter int B_AW  = 32,
    parameter int B_DW  = 32,
    parameter int B_WW  = 37,
    parameter int CNT_W = 16
);
    logic [B_AW-1:0]  cmdaddr;
    logic [CNT_W-1:0] cmdcnt;
    logic             cmdvld;
    logic             cmdrdy;
    logic [B_AW-1:0]  wraddr;
    logic [B_WW-1:0]  wrdata;
    logic             wrvld;
    logic             wrrdy;
    logic [B_AW-1:0]  rsaddr;
    logic [B_WW-1:0]  rsdata;
    logic             rsvld;
    logic             rsrdy;
    logic [B_DW-1:0]  respdata;
    logic [CNT_W-1:0] respidx;
    logic             respvld;
    logic             resprdy;
    logic             done;
    logic             err;

    modport master (
        input  cmdaddr, cmdcnt, cmdvld, wrrdy, rsaddr, rsdata, rsvld, resprdy,
        output cmdrdy, wraddr, wrdata, wrvld, rsrdy, respdata, respidx, respvld, done, err
    );

    modport slave (
        output cmdaddr, cmdcnt, cmdvld, wrrdy, rsaddr, rsdata, rsvld, resprdy,
        input  cmdrdy, wraddr, wrdata, wrvld, rsrdy, respdata, respidx, respvld, done, err
    );
endinterface

// File: rtl/powlib_iprdreq.sv
// Read-request master for the IP RAM slave: issues a burst of credit-limited READs
// and returns indexed read data. Optional sequence checking via POWLIB_IPRDREQ_CHECK_EN.
module powlib_iprdreq
    import powlib_pkg::*;
#(
    parameter int              B_BPD    = 4,
    parameter int              B_AW     = POWLIB_BW * B_BPD,
    parameter logic [B_AW-1:0] RET_BASE = '0,
    parameter int              MAX_OUT  = 8,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    powlib_iprdreq_if.master bus
);
    localparam int B_DW   = POWLIB_BW * B_BPD;
    localparam int B_BEW  = B_BPD;
    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int IDX_SH = $clog2(B_BPD);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [B_AW-1:0]  STRIDE    = B_AW'(B_BPD);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [B_AW-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             zdone_q, zdone_d;
    logic             respvld_q, respvld_d;
    logic [B_DW-1:0]  respdata_q, respdata_d;
    logic [CNT_W-1:0] respidx_q, respidx_d;

    logic             cmdrdy, cmd_acc, wrvld, wr_acc, rsrdy, rs_acc, drain_done;
    logic [B_AW-1:0]  req_ofs, ret_addr, rs_rel;

    assign req_ofs  = B_AW'(off_q) * STRIDE;
    assign ret_addr = RET_BASE + req_ofs;
    assign rs_rel   = bus.rsaddr - RET_BASE;
    assign rsrdy    = !respvld_q || bus.resprdy;
    assign rs_acc   = bus.rsvld && rsrdy;

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        zdone_d    = 1'b0;
        cmdrdy     = 1'b0;
        wrvld      = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Reset clears the state to IDLE, so hide readiness while rst is held.
                cmdrdy = !rst;
                if (bus.cmdvld && cmdrdy) begin
                    addr_d = bus.cmdaddr;
                    cnt_d  = bus.cmdcnt;
                    off_d  = '0;
                    if (bus.cmdcnt == '0) zdone_d = 1'b1;
                    else                  state_d = ISSUE;
                end
            end
            ISSUE: begin
                wrvld = (out_q < MAX_OUT_C);
                if (wrvld && bus.wrrdy) begin
                    off_d = off_q + CNT_W'(1);
                    if (off_d == cnt_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_q == '0) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_acc = bus.cmdvld && cmdrdy;
    assign wr_acc  = wrvld && bus.wrrdy;

    always_comb begin
        out_d = out_q;
        if (wr_acc && !rs_acc)                    out_d = out_q + OUT_W'(1);
        else if (!wr_acc && rs_acc && out_q != '0) out_d = out_q - OUT_W'(1);

        respvld_d  = respvld_q;
        respdata_d = respdata_q;
        respidx_d  = respidx_q;
        if (rs_acc) begin
            respvld_d  = 1'b1;
            respdata_d = bus.rsdata[B_DW-1:0];
            respidx_d  = CNT_W'(rs_rel >> IDX_SH);
        end else if (bus.resprdy) begin
            respvld_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            off_q      <= '0;
            out_q      <= '0;
            zdone_q    <= 1'b0;
            respvld_q  <= 1'b0;
            respdata_q <= '0;
            respidx_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            out_q      <= out_d;
            zdone_q    <= zdone_d;
            respvld_q  <= respvld_d;
            respdata_q <= respdata_d;
            respidx_q  <= respidx_d;
        end
    end

    assign bus.cmdrdy   = cmdrdy;
    assign bus.wrvld    = wrvld;
    assign bus.wraddr   = addr_q + req_ofs;
    assign bus.wrdata   = {POWLIB_OP_READ, {B_BEW{1'b1}}, B_DW'(ret_addr)};
    assign bus.rsrdy    = rsrdy;
    assign bus.respvld  = respvld_q;
    assign bus.respdata = respdata_q;
    assign bus.respidx  = respidx_q;
    // Zero-length commands finish from IDLE one cycle later; bursts finish from DRAIN.
    assign bus.done     = zdone_q || drain_done;

`ifdef POWLIB_IPRDREQ_CHECK_EN
    logic [CNT_W-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic [B_AW-1:0]  exp_addr;

    assign exp_addr = RET_BASE + B_AW'(exp_q) * STRIDE;

    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if (cmd_acc)     exp_d = '0;
        else if (rs_acc) exp_d = exp_q + CNT_W'(1);
        if (rs_acc && (out_q == '0 || bus.rsaddr != exp_addr)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_powlib_iprdreq.sv
// Directed bench for powlib_iprdreq: burst issue, credit limit, response indexing,
// zero-length command, mid-burst reset, address wrap and the optional error flag.
module tb_powlib_iprdreq;
    import powlib_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WW = 37;
    localparam int CW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] ret;
    } issue_t;

    typedef struct {
        logic          rsvld;
        logic [AW-1:0] rsaddr;
        logic [DW-1:0] rsdata;
        logic          resprdy;
        logic          x_rsrdy;
        logic          x_done;
        logic          x_cmdrdy;
        logic          x_respvld;
        logic [CW-1:0] x_idx;
        logic [DW-1:0] x_data;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    powlib_iprdreq_if #(.B_AW(AW), .B_DW(DW), .B_WW(WW), .CNT_W(CW)) ifa ();
    powlib_iprdreq_if #(.B_AW(AW), .B_DW(DW), .B_WW(WW), .CNT_W(CW)) ifb ();

    powlib_iprdreq #(.B_BPD(4), .B_AW(AW), .RET_BASE(32'h100), .MAX_OUT(8), .CNT_W(CW))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    powlib_iprdreq #(.B_BPD(4), .B_AW(AW), .RET_BASE(32'h100), .MAX_OUT(2), .CNT_W(CW))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] req_word(input logic [AW-1:0] ret);
        return {POWLIB_OP_READ, 4'hF, ret};
    endfunction

    issue_t iss[4];
    resp_t  rv[9];
    int     n_req;

    initial begin
        iss[0] = '{32'h10, 32'h100};
        iss[1] = '{32'h14, 32'h104};
        iss[2] = '{32'h18, 32'h108};
        iss[3] = '{32'h1C, 32'h10C};
        //        vld   rsaddr      data     rdy   rsrdy done cmdrdy respvld idx    data
        rv[0] = '{1'b1, 32'h100, 32'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 32'hA};
        rv[1] = '{1'b1, 32'h104, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'hA};
        rv[2] = '{1'b1, 32'h104, 32'hB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 32'hB};
        rv[3] = '{1'b1, 32'h108, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 32'hB};
        rv[4] = '{1'b1, 32'h108, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 32'hC};
        rv[5] = '{1'b1, 32'h10C, 32'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 32'hC};
        rv[6] = '{1'b1, 32'h10C, 32'hD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 32'hD};
        rv[7] = '{1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 32'hD};
        rv[8] = '{1'b0, 32'h0,   32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 32'h0};

        rst = 1'b1;
        ifa.cmdaddr = '0; ifa.cmdcnt = '0; ifa.cmdvld = 1'b0; ifa.wrrdy = 1'b1;
        ifa.rsaddr = '0;  ifa.rsdata = '0; ifa.rsvld = 1'b0;  ifa.resprdy = 1'b0;
        ifb.cmdaddr = '0; ifb.cmdcnt = '0; ifb.cmdvld = 1'b0; ifb.wrrdy = 1'b1;
        ifb.rsaddr = '0;  ifb.rsdata = '0; ifb.rsvld = 1'b0;  ifb.resprdy = 1'b0;

        // Reset state
        #1;
        check("rst_cmdrdy", 64'(ifa.cmdrdy), 64'(0));
        check("rst_wrvld", 64'(ifa.wrvld), 64'(0));
        check("rst_respvld", 64'(ifa.respvld), 64'(0));
        check("rst_done", 64'(ifa.done), 64'(0));
        check("rst_err", 64'(ifa.err), 64'(0));
        step(); step();
        rst = 1'b0;
        #1;
        check("idle_cmdrdy", 64'(ifa.cmdrdy), 64'(1));

        // Four-word burst: one request per cycle
        ifa.cmdaddr = 32'h10; ifa.cmdcnt = 16'd4; ifa.cmdvld = 1'b1;
        step();
        ifa.cmdvld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("iss%0d_wrvld", i), 64'(ifa.wrvld), 64'(1));
            check($sformatf("iss%0d_wraddr", i), 64'(ifa.wraddr), 64'(iss[i].addr));
            check($sformatf("iss%0d_wrdata", i), 64'(ifa.wrdata), 64'(req_word(iss[i].ret)));
            check($sformatf("iss%0d_cmdrdy", i), 64'(ifa.cmdrdy), 64'(0));
            step();
        end
        check("drain_wrvld", 64'(ifa.wrvld), 64'(0));

        // Responses with back-pressure toggling
        for (int i = 0; i < 9; i++) begin
            ifa.rsvld   = rv[i].rsvld;
            ifa.rsaddr  = rv[i].rsaddr;
            ifa.rsdata  = {1'b0, 4'h0, rv[i].rsdata};
            ifa.resprdy = rv[i].resprdy;
            #1;
            check($sformatf("rv%0d_rsrdy", i), 64'(ifa.rsrdy), 64'(rv[i].x_rsrdy));
            check($sformatf("rv%0d_done", i), 64'(ifa.done), 64'(rv[i].x_done));
            check($sformatf("rv%0d_cmdrdy", i), 64'(ifa.cmdrdy), 64'(rv[i].x_cmdrdy));
            step();
            check($sformatf("rv%0d_respvld", i), 64'(ifa.respvld), 64'(rv[i].x_respvld));
            if (rv[i].x_respvld) begin
                check($sformatf("rv%0d_idx", i), 64'(ifa.respidx), 64'(rv[i].x_idx));
                check($sformatf("rv%0d_data", i), 64'(ifa.respdata), 64'(rv[i].x_data));
            end
        end
        ifa.rsvld = 1'b0; ifa.resprdy = 1'b1;

        // Zero-length command
        ifa.cmdaddr = 32'h50; ifa.cmdcnt = 16'd0; ifa.cmdvld = 1'b1;
        #1;
        check("z_cmdrdy0", 64'(ifa.cmdrdy), 64'(1));
        step();
        ifa.cmdvld = 1'b0;
        check("z_done", 64'(ifa.done), 64'(1));
        check("z_wrvld", 64'(ifa.wrvld), 64'(0));
        check("z_cmdrdy1", 64'(ifa.cmdrdy), 64'(1));
        step();
        check("z_done_off", 64'(ifa.done), 64'(0));
        check("z_wrvld2", 64'(ifa.wrvld), 64'(0));

        // Credit limit on MAX_OUT=2, after a stray response in IDLE (counter must saturate)
        ifb.rsvld = 1'b1; ifb.rsaddr = 32'h10C; ifb.rsdata = {1'b0, 4'h0, 32'h55}; ifb.resprdy = 1'b1;
        step();
        ifb.rsvld = 1'b0;
        check("stray_respvld", 64'(ifb.respvld), 64'(1));
        check("stray_idx", 64'(ifb.respidx), 64'(3));
`ifndef POWLIB_IPRDREQ_CHECK_EN
        check("stray_err_off", 64'(ifb.err), 64'(0));
`endif
        ifb.cmdaddr = 32'h200; ifb.cmdcnt = 16'd5; ifb.cmdvld = 1'b1;
        step();
        ifb.cmdvld = 1'b0;
        n_req = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifb.wrvld && ifb.wrrdy) n_req++;
            step();
        end
        check("credit_first", 64'(n_req), 64'(2));
        check("credit_stall", 64'(ifb.wrvld), 64'(0));
        ifb.rsvld = 1'b1; ifb.rsaddr = 32'h100; ifb.rsdata = {1'b0, 4'h0, 32'h77};
        #1;
        check("credit_rsrdy", 64'(ifb.rsrdy), 64'(1));
        step();
        ifb.rsvld = 1'b0;
        check("credit_wraddr", 64'(ifb.wraddr), 64'(32'h208));
        check("credit_wrdata", 64'(ifb.wrdata), 64'(req_word(32'h108)));
        n_req = 0;
        for (int i = 0; i < 4; i++) begin
            if (ifb.wrvld && ifb.wrrdy) n_req++;
            step();
        end
        check("credit_one_more", 64'(n_req), 64'(1));
        check("credit_stall2", 64'(ifb.wrvld), 64'(0));

        // Reset in the middle of a burst (off=2 of 6)
        ifa.cmdaddr = 32'h40; ifa.cmdcnt = 16'd6; ifa.cmdvld = 1'b1;
        step();
        ifa.cmdvld = 1'b0;
        step(); step();
        check("mid_wraddr", 64'(ifa.wraddr), 64'(32'h48));
        check("mid_wrdata", 64'(ifa.wrdata), 64'(req_word(32'h108)));
        rst = 1'b1;
        #1;
        check("mid_rst_wrvld", 64'(ifa.wrvld), 64'(0));
        check("mid_rst_cmdrdy", 64'(ifa.cmdrdy), 64'(0));
        check("mid_rst_b_wrvld", 64'(ifb.wrvld), 64'(0));
        step();
        rst = 1'b0;
        #1;
        check("mid_idle_cmdrdy", 64'(ifa.cmdrdy), 64'(1));
        check("mid_idle_wrvld", 64'(ifa.wrvld), 64'(0));

        // Restart from offset 0 with an address that wraps
        ifa.cmdaddr = 32'hFFFF_FFFC; ifa.cmdcnt = 16'd2; ifa.cmdvld = 1'b1;
        step();
        ifa.cmdvld = 1'b0;
        check("wrap0_wraddr", 64'(ifa.wraddr), 64'(32'hFFFF_FFFC));
        check("wrap0_wrdata", 64'(ifa.wrdata), 64'(req_word(32'h100)));
        step();
        check("wrap1_wraddr", 64'(ifa.wraddr), 64'(32'h0));
        check("wrap1_wrdata", 64'(ifa.wrdata), 64'(req_word(32'h104)));
        step();
        check("wrap_drain_wrvld", 64'(ifa.wrvld), 64'(0));
        ifa.rsvld = 1'b1; ifa.rsaddr = 32'h100; ifa.rsdata = {1'b1, 4'hF, 32'h11};
        step();
        check("wrap_r0_idx", 64'(ifa.respidx), 64'(0));
        check("wrap_r0_data", 64'(ifa.respdata), 64'(32'h11));
        check("wrap_r0_done", 64'(ifa.done), 64'(0));
        ifa.rsaddr = 32'h104; ifa.rsdata = {1'b1, 4'hF, 32'h22};
        step();
        ifa.rsvld = 1'b0;
        check("wrap_r1_idx", 64'(ifa.respidx), 64'(1));
        check("wrap_r1_data", 64'(ifa.respdata), 64'(32'h22));
        check("wrap_done", 64'(ifa.done), 64'(1));
        check("wrap_done_cmdrdy", 64'(ifa.cmdrdy), 64'(0));
        step();
        check("wrap_done_off", 64'(ifa.done), 64'(0));
        check("wrap_cmdrdy", 64'(ifa.cmdrdy), 64'(1));
        check("wrap_respvld_off", 64'(ifa.respvld), 64'(0));
        check("wrap_err", 64'(ifa.err), 64'(0));

`ifdef POWLIB_IPRDREQ_CHECK_EN
        // Out-of-sequence return address sets the sticky error
        ifa.cmdaddr = 32'h0; ifa.cmdcnt = 16'd2; ifa.cmdvld = 1'b1;
        step();
        ifa.cmdvld = 1'b0;
        step(); step();
        ifa.rsvld = 1'b1; ifa.rsaddr = 32'h100;
        step();
        check("chk_err_ok", 64'(ifa.err), 64'(0));
        ifa.rsaddr = 32'h108;
        step();
        ifa.rsvld = 1'b0;
        check("chk_err_seq", 64'(ifa.err), 64'(1));
        step(); step();
        check("chk_err_sticky", 64'(ifa.err), 64'(1));
        rst = 1'b1;
        #1;
        check("chk_err_rst", 64'(ifa.err), 64'(0));
        step();
        rst = 1'b0;
        ifa.rsvld = 1'b1; ifa.rsaddr = 32'h100;
        step();
        ifa.rsvld = 1'b0;
        check("chk_err_stray", 64'(ifa.err), 64'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
